// File: rtl/fifo_pkt_reader_if.sv
// Bundles the FIFO read port and the outgoing byte stream of the packet reader.
// master = the reader; slave = the FIFO/downstream side.
`timescale 1ns/1ps

interface fifo_pkt_reader_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_empty;
    logic              fifo_rd;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_sop;
    logic              tx_eop;
    logic              tx_ready;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        input  tx_ready,
        output fifo_rd,
        output tx_data,
        output tx_valid,
        output tx_sop,
        output tx_eop
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        output tx_ready,
        input  fifo_rd,
        input  tx_data,
        input  tx_valid,
        input  tx_sop,
        input  tx_eop
    );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Drains length-prefixed packets from a show-ahead byte FIFO onto a registered
// valid/ready stream with sop/eop framing; bad lengths are flagged and dropped.
//
// state | meaning
// IDLE  | waiting for enable and a length byte at the FIFO head
// DATA  | forwarding payload bytes into the output register
// DROP  | discarding the payload of an illegal-length packet
`timescale 1ns/1ps

module fifo_pkt_reader #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    fifo_pkt_reader_if.master bus,
    output logic              len_err,
    output logic [7:0]        pkt_cnt,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);
    localparam logic [DATA_W-1:0] MAX_LEN_W = DATA_W'(MAX_LEN);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] remaining;
    logic              first;

    logic pop_len;
    logic pop_data;
    logic pop_drop;
    logic accept;
    logic len_zero;
    logic len_big;
    logic last_byte;

    assign accept    = bus.tx_valid && bus.tx_ready;
    assign len_zero  = (bus.fifo_data == '0);
    assign len_big   = (bus.fifo_data > MAX_LEN_W);
    assign last_byte = (remaining == ONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pop_len && !len_zero) begin
                    state_nxt = len_big ? DROP : DATA;
                end
            end
            DATA: begin
                if (pop_data && last_byte) begin
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                if (pop_drop && last_byte) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pop strobes; gating on fifo_empty here is what makes underflow impossible
    always_comb begin
        pop_len  = 1'b0;
        pop_data = 1'b0;
        pop_drop = 1'b0;
        if (!rst && !bus.fifo_empty) begin
            case (state)
                IDLE:    pop_len  = enable;
                DATA:    pop_data = !bus.tx_valid || bus.tx_ready;
                DROP:    pop_drop = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.fifo_rd = pop_len || pop_data || pop_drop;
    assign busy        = (state != IDLE) || bus.tx_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining    <= '0;
            first        <= 1'b0;
            len_err      <= 1'b0;
            pkt_cnt      <= 8'd0;
            bus.tx_data  <= '0;
            bus.tx_valid <= 1'b0;
            bus.tx_sop   <= 1'b0;
            bus.tx_eop   <= 1'b0;
        end else begin
            len_err <= pop_len && (len_zero || len_big);

            if (pop_len) begin
                remaining <= bus.fifo_data;
                first     <= 1'b1;
            end else if (pop_data || pop_drop) begin
                remaining <= remaining - ONE;
                first     <= 1'b0;
            end

            // Reload on pop even when the current beat is being accepted: no bubble
            if (pop_data) begin
                bus.tx_data  <= bus.fifo_data;
                bus.tx_valid <= 1'b1;
                bus.tx_sop   <= first;
                bus.tx_eop   <= last_byte;
            end else if (accept) begin
                bus.tx_valid <= 1'b0;
            end

            if (accept && bus.tx_eop) begin
                pkt_cnt <= pkt_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/fifo_pkt_reader.md
Name: fifo_pkt_reader

Overview:
Read-side consumer for the transaction-layer byte FIFO (16-deep, 8-bit, show-ahead read). Drains length-prefixed packets from the FIFO and presents them on a registered valid/ready byte stream with start/end-of-packet framing. Malformed length bytes are flagged, and their payloads are discarded without reaching the stream. The block sits between the FIFO read port and the downstream TLP transmit logic.

Parameters:
DATA_W, 8, FIFO/stream byte width; the length field is also DATA_W bits.
MAX_LEN, 64, largest legal payload length in bytes (1..255).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
enable  input  1  allow a new packet to start; sampled only in IDLE
fifo_data  input  DATA_W  FIFO head byte; valid in the same cycle whenever fifo_empty=0
fifo_empty  input  1  FIFO empty flag
fifo_rd  output  1  pop strobe, combinational; one byte popped per cycle asserted
tx_data  output  DATA_W  stream byte, registered
tx_valid  output  1  stream byte valid
tx_sop  output  1  first payload byte of a packet; qualified by tx_valid
tx_eop  output  1  last payload byte of a packet; qualified by tx_valid
tx_ready  input  1  downstream accepts the byte when tx_valid && tx_ready
len_err  output  1  one-cycle pulse on an illegal length byte
pkt_cnt  output  8  count of packets whose eop beat was accepted; wraps 255->0
busy  output  1  state!=IDLE or tx_valid=1

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; tx_data=0; tx_valid=tx_sop=tx_eop=0; len_err=0; pkt_cnt=0; remaining=0. fifo_rd=0 while rst=1.
- fifo_rd is never asserted while fifo_empty=1, so the block cannot underflow the FIFO.
- FIFO packet format: one length byte L, followed by L payload bytes.
- State IDLE:
  - If enable=1 and fifo_empty=0: assert fifo_rd and latch L=fifo_data.
  - L=0: pulse len_err; stay in IDLE.
  - L>MAX_LEN: pulse len_err; remaining=L; go to DROP.
  - Otherwise: remaining=L; first=1; go to DATA.
- State DATA:
  - Pop condition: fifo_empty=0 and (tx_valid=0 or tx_ready=1).
  - On a pop, the next edge loads tx_data=fifo_data, tx_valid=1, tx_sop=first, tx_eop=(remaining==1). Then first=0 and remaining is decremented.
  - When remaining reaches 0, go to IDLE.
- State DROP:
  - Pop whenever fifo_empty=0; decrement remaining; tx_* unchanged.
  - When remaining reaches 0, go to IDLE.
- Output register:
  - When tx_valid=1 and tx_ready=0, tx_data, tx_sop and tx_eop hold stable and no pop occurs.
  - On acceptance with no new pop in the same cycle, tx_valid clears at the next edge.
  - Simultaneous accept and pop: the register reloads and tx_valid stays 1, with no bubble.
- Latency: a byte popped at edge k is on tx_data from edge k to the next edge. Sustained throughput is 1 byte/clk when fifo_empty=0 and tx_ready=1.
- IDLE may pop the next length byte while the previous eop byte is still held in the output register; the length path does not use the output register.
- pkt_cnt increments on the cycle tx_valid && tx_ready && tx_eop.
- enable=0 does not stop a packet in progress (DATA/DROP runs to completion).
- FIFO empty mid-packet: stall in DATA/DROP without popping and resume when data arrives. There is no timeout.
- Reset mid-packet: the packet is abandoned and all state is cleared. The FIFO shares rst, so alignment is preserved.
- len_err is high for exactly one cycle per bad length byte.

Test Plan:
- Basic: FIFO={3,A1,A2,A3}, enable=1, tx_ready=1 -> 3 consecutive beats A1(sop),A2,A3(eop); pkt_cnt=1; fifo_rd high for 4 cycles.
- Backpressure: same packet, tx_ready low for 3 cycles after the first beat -> A1 held stable, no pop while stalled; full packet then delivered in order; pkt_cnt=1.
- Back-to-back: FIFO={1,B0,2,C0,C1} -> B0 (sop+eop), then C0 (sop), C1 (eop); at most one idle stream cycle between packets (the length pop); pkt_cnt=2.
- Bad length: FIFO={0,70,x*70,2,D0,D1}, MAX_LEN=64 -> len_err pulses twice; the 70 payload bytes are popped with tx_valid=0; then D0/D1 delivered; pkt_cnt=1.
- Underrun and reset: write {4,E0,E1} and stall, then write E2,E3 10 cycles later -> E0..E3 delivered with busy=1 throughout. Repeat with rst=1 mid-packet -> all outputs 0 and state IDLE the next cycle.
